bcd_time_counter: RTL and testbench
===================================

// Module: bcd_time_counter
// PURPOSE
//  Time-of-day keeper directly downstream of the Clock stage: consumes CLK,
//  divides it to a one-second tick and keeps hours:minutes:seconds (24 h).
//  Feeds the display/alarm stages with registered time plus tick/rollover
//  strobes. Time can be preset at runtime through a single-cycle load port.
// PARAMETERS
//  TICK_DIV  10  CLK cycles per second tick (>=2; 10 for sim, board value at top)
// PORTS
//  CLK       in   1   system clock; all logic on posedge CLK
//  RST       in   1   synchronous reset, active-high
//  EN        in   1   1 = run prescaler/time; 0 = freeze (load still honoured)
//  LOAD      in   1   one-cycle strobe: preset time from LD_* this edge
//  LD_HOUR   in   5   preset hours   (0..23 valid)
//  LD_MIN    in   6   preset minutes (0..59 valid)
//  LD_SEC    in   6   preset seconds (0..59 valid)
//  HOUR      out  5   current hours, binary 0..23
//  MIN       out  6   current minutes, binary 0..59
//  SEC       out  6   current seconds, binary 0..59
//  TICK      out  1   one-cycle pulse, high in the cycle new time is visible
//  ROLLOVER  out  1   one-cycle pulse, high when time wraps 23:59:59 -> 00:00:00
//  LOAD_ERR  out  1   one-cycle pulse: LOAD rejected (a field out of range)
// BEHAVIOUR
//  - Reset (RST=1 at posedge): HOUR=MIN=SEC=0, prescaler=0, TICK=ROLLOVER=LOAD_ERR=0.
//    RST overrides LOAD and EN; reset mid-count discards prescaler progress.
//  - Prescaler: counts 0..TICK_DIV-1 while EN=1, holds while EN=0.
//    Width = $clog2(TICK_DIV). Wraps to 0 after TICK_DIV-1.
//  - Advance: at posedge with EN=1, LOAD=0, prescaler==TICK_DIV-1:
//    prescaler<=0, SEC+1; SEC 59->0 carries MIN+1; MIN 59->0 carries HOUR+1;
//    HOUR 23->0. TICK<=1 same edge (TICK and new time appear together).
//    First tick after reset/load arrives TICK_DIV cycles later.
//  - ROLLOVER<=1 only on the advance from 23:59:59 to 00:00:00; LOAD of
//    00:00:00 does not raise it.
//  - All strobe outputs are registered and default to 0 every cycle.
//  - Load (priority over advance): at posedge with LOAD=1:
//    all fields valid -> HOUR/MIN/SEC<=LD_*, prescaler<=0, TICK=0 that cycle
//    (a coinciding advance is dropped, not deferred).
//    any field invalid -> time and prescaler unchanged and advance still
//    suppressed this edge, LOAD_ERR<=1 for one cycle.
//    Load works regardless of EN.
//  - No combinational path input->output; all outputs change only at posedge CLK.
//  - EN deassert mid-second: prescaler value retained; resumes from same count.
// TESTING  (CLK period 10 ns, TICK_DIV=10)
//  1 Reset: RST=1 2 cycles, release, EN=1 -> time 00:00:00, first TICK
//    exactly 10 cycles after RST low, SEC=1 in that cycle.
//  2 Carry: LOAD 00:00:58, EN=1 -> after 20 cycles 00:01:00, TICK pulses
//    1 cycle wide every 10 cycles.
//  3 Midnight: LOAD 23:59:59 -> 10 cycles later 00:00:00, ROLLOVER=1 with
//    TICK for exactly 1 cycle; LOAD 00:00:00 -> ROLLOVER stays 0.
//  4 Bad load: LOAD 24:00:00 (then 12:60:00) -> LOAD_ERR 1 cycle, time
//    unchanged, no TICK that edge.
//  5 Freeze: EN=0 after 4 prescaler counts for 50 cycles -> no TICK, time
//    constant; EN=1 -> TICK after 6 more cycles.
//  6 Collision: LOAD 10:20:30 on the edge a tick is due -> time = 10:20:30,
//    TICK=0, next TICK 10 cycles later shows 10:20:31; RST with LOAD -> 0s.

Source files
------------

// File: rtl/bcd_time_counter_if.sv
// Signal bundle between the time-of-day keeper and its user
// (a control block or a testbench on one side, the counter on the other).
//
// Transfer rules: there is no valid/ready pair on this bundle. LOAD is a
// single-cycle strobe that the counter always takes in on the posedge where
// it is high. The counter answers on the next cycle, either with the new time
// or with a one-cycle LOAD_ERR pulse. TICK, ROLLOVER and LOAD_ERR are
// registered one-cycle pulses. Each one is high for exactly one cycle per
// event, and the user has no way to stall them.
interface bcd_time_counter_if;
  logic       EN;
  logic       LOAD;
  logic [4:0] LD_HOUR;
  logic [5:0] LD_MIN;
  logic [5:0] LD_SEC;
  logic [4:0] HOUR;
  logic [5:0] MIN;
  logic [5:0] SEC;
  logic       TICK;
  logic       ROLLOVER;
  logic       LOAD_ERR;

  // Controller side: drives run/load controls, observes time and strobes
  modport master (
    output EN, LOAD, LD_HOUR, LD_MIN, LD_SEC,
    input  HOUR, MIN, SEC, TICK, ROLLOVER, LOAD_ERR
  );

  // Counter side
  modport slave (
    input  EN, LOAD, LD_HOUR, LD_MIN, LD_SEC,
    output HOUR, MIN, SEC, TICK, ROLLOVER, LOAD_ERR
  );
endinterface

// File: rtl/bcd_time_counter.sv
// 24-hour time-of-day keeper. A prescaler divides CLK down to a
// one-second advance. The block keeps hours, minutes and seconds in binary.
// It can also be preset at runtime through a one-cycle LOAD strobe. Every
// output is a register, so nothing passes combinationally from input to output.
module bcd_time_counter #(
  parameter int TICK_DIV = 10
) (
  input  logic                CLK,
  input  logic                RST,
  bcd_time_counter_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q,  hour_d;
  logic [5:0]    min_q,   min_d;
  logic [5:0]    sec_q,   sec_d;
  logic          tick_q,  tick_d;
  logic          roll_q,  roll_d;
  logic          err_q,   err_d;
  logic          load_ok;

  assign load_ok = (bus.LD_HOUR < 5'd24) && (bus.LD_MIN < 6'd60) &&
                   (bus.LD_SEC < 6'd60);

  // Next-state logic: a load (good or bad) beats an advance on the same edge
  always_comb begin
    presc_d = presc_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.LOAD) begin
      // A rejected load still swallows any advance due on this edge
      if (load_ok) begin
        hour_d  = bus.LD_HOUR;
        min_d   = bus.LD_MIN;
        sec_d   = bus.LD_SEC;
        presc_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.EN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hour_q == 5'd23) begin
              hour_d = 5'd0;
              roll_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State registers; reset wins over LOAD and EN and drops prescaler progress
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
      err_q   <= err_d;
    end
  end

  assign bus.HOUR     = hour_q;
  assign bus.MIN      = min_q;
  assign bus.SEC      = sec_q;
  assign bus.TICK     = tick_q;
  assign bus.ROLLOVER = roll_q;
  assign bus.LOAD_ERR = err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter with TICK_DIV=10 and a 10 ns clock.
// Each scenario pushes the expected output snapshot
// {HOUR,MIN,SEC,TICK,ROLLOVER,LOAD_ERR} before driving a clock edge, then
// pops it and compares it against the registered outputs 1 ns after that edge.
module tb_bcd_time_counter;

  localparam int W = 20;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp;

  // Current model time, kept by the bench across scenarios
  int m_h, m_m, m_s;

  bcd_time_counter_if bus ();

  bcd_time_counter #(.TICK_DIV(10)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  wire [W-1:0] obs = {bus.HOUR, bus.MIN, bus.SEC, bus.TICK, bus.ROLLOVER, bus.LOAD_ERR};

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] pk(int h, int m, int s, int t, int r, int e);
    return {5'(h), 6'(m), 6'(s), 1'(t), 1'(r), 1'(e)};
  endfunction

  function automatic string fmt(logic [W-1:0] v);
    return $sformatf("%0d:%0d:%0d tick=%0b roll=%0b err=%0b",
                     v[19:15], v[14:9], v[8:3], v[2], v[1], v[0]);
  endfunction

  // Reference one-second advance; returns 1 when it wraps at midnight
  function automatic bit advance(inout int h, inout int m, inout int s);
    s = s + 1;
    if (s == 60) begin s = 0; m = m + 1; end
    if (m == 60) begin m = 0; h = h + 1; end
    if (h == 24) begin h = 0; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(int h, int m, int s);
    bus.LOAD    = 1'b1;
    bus.LD_HOUR = 5'(h);
    bus.LD_MIN  = 6'(m);
    bus.LD_SEC  = 6'(s);
  endtask

  // Reset, then the first tick arrives exactly 10 cycles after release
  task automatic test_reset();
    rst = 1'b1;
    bus.EN = 1'b1;
    set_load(7, 7, 7);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
    rst = 1'b0;
    bus.LOAD = 1'b0;
    m_h = 0; m_m = 0; m_s = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) void'(advance(m_h, m_m, m_s));
      exp_q.push_back(pk(m_h, m_m, m_s, (i == 10), 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL first_tick[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  // Seconds-to-minutes carry: load 00:00:58, expect 00:01:00 twenty cycles later
  task automatic test_carry();
    set_load(0, 0, 58);
    m_h = 0; m_m = 0; m_s = 58;
    exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
    step();
    bus.LOAD = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL carry_load: got %s want %s", fmt(obs), fmt(exp));
    end
    for (int i = 1; i <= 20; i++) begin
      if (i % 10 == 0) void'(advance(m_h, m_m, m_s));
      exp_q.push_back(pk(m_h, m_m, m_s, (i % 10 == 0), 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL carry[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
    n_checks++;
    if ({bus.HOUR, bus.MIN, bus.SEC} !== {5'd0, 6'd1, 6'd0}) begin
      n_fail++;
      $display("FAIL carry_final: got %0d:%0d:%0d want 0:1:0", bus.HOUR, bus.MIN, bus.SEC);
    end
  endtask

  // Midnight wrap raises ROLLOVER; a load of 00:00:00 does not
  task automatic test_midnight();
    set_load(23, 59, 59);
    m_h = 23; m_m = 59; m_s = 59;
    exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
    step();
    bus.LOAD = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL midnight_load: got %s want %s", fmt(obs), fmt(exp));
    end
    for (int i = 1; i <= 11; i++) begin
      bit r;
      r = 1'b0;
      if (i == 10) r = advance(m_h, m_m, m_s);
      exp_q.push_back(pk(m_h, m_m, m_s, (i == 10), r, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL midnight[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
    set_load(0, 0, 0);
    m_h = 0; m_m = 0; m_s = 0;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step();
    bus.LOAD = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL zero_load_no_roll: got %s want %s", fmt(obs), fmt(exp));
    end
  endtask

  // Out-of-range loads: LOAD_ERR for one cycle, time and prescaler untouched
  task automatic test_bad_load();
    int bad_h[3] = '{24, 12, 0};
    int bad_m[3] = '{0, 60, 0};
    int bad_s[3] = '{0, 0, 60};
    // Prescaler is 0 after the preceding load; walk it to the tick-due value
    for (int k = 0; k < 3; k++) begin
      for (int i = 1; i <= 9; i++) begin
        exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
        step();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL bad_pre[%0d.%0d]: got %s want %s", k, i, fmt(obs), fmt(exp));
        end
      end
      set_load(bad_h[k], bad_m[k], bad_s[k]);
      exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 1));
      step();
      bus.LOAD = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL bad_load[%0d]: got %s want %s", k, fmt(obs), fmt(exp));
      end
      // The prescaler was held, so the suppressed advance comes on the next edge
      void'(advance(m_h, m_m, m_s));
      exp_q.push_back(pk(m_h, m_m, m_s, 1, 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL bad_after[%0d]: got %s want %s", k, fmt(obs), fmt(exp));
      end
    end
  endtask

  // EN low mid-second freezes everything; resume finishes the same second
  task automatic test_freeze();
    set_load(5, 6, 7);
    m_h = 5; m_m = 6; m_s = 7;
    exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
    step();
    bus.LOAD = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL freeze_load: got %s want %s", fmt(obs), fmt(exp));
    end
    for (int i = 0; i < 54; i++) begin
      bus.EN = (i < 4);
      exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL freeze[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
    bus.EN = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) void'(advance(m_h, m_m, m_s));
      exp_q.push_back(pk(m_h, m_m, m_s, (i == 6), 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL resume[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  // Load on a tick-due edge drops the tick; reset beats load; load with EN=0
  task automatic test_collision();
    for (int i = 1; i <= 9; i++) begin
      exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL coll_pre[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
    set_load(10, 20, 30);
    m_h = 10; m_m = 20; m_s = 30;
    exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
    step();
    bus.LOAD = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL coll_load: got %s want %s", fmt(obs), fmt(exp));
    end
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) void'(advance(m_h, m_m, m_s));
      exp_q.push_back(pk(m_h, m_m, m_s, (i == 10), 0, 0));
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL coll_next[%0d]: got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
    rst = 1'b1;
    set_load(5, 5, 5);
    m_h = 0; m_m = 0; m_s = 0;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    bus.EN = 1'b0;
    set_load(3, 4, 5);
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL rst_over_load: got %s want %s", fmt(obs), fmt(exp));
    end
    m_h = 3; m_m = 4; m_s = 5;
    exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
    step();
    bus.LOAD = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL load_en_off: got %s want %s", fmt(obs), fmt(exp));
    end
  endtask

  // Random valid presets, each followed by one full second of running
  task automatic test_random_load();
    bus.EN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        m_h = 23; m_m = 59; m_s = 59;
      end else begin
        m_h = $urandom_range(0, 23);
        m_m = $urandom_range(0, 59);
        m_s = $urandom_range(0, 59);
      end
      set_load(m_h, m_m, m_s);
      exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 0));
      step();
      bus.LOAD = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rnd_load[%0d]: got %s want %s", k, fmt(obs), fmt(exp));
      end
      for (int i = 1; i <= 10; i++) begin
        bit r;
        r = 1'b0;
        if (i == 10) r = advance(m_h, m_m, m_s);
        exp_q.push_back(pk(m_h, m_m, m_s, (i == 10), r, 0));
        step();
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL rnd_run[%0d.%0d]: got %s want %s", k, i, fmt(obs), fmt(exp));
        end
      end
      set_load($urandom_range(24, 31), $urandom_range(0, 59), $urandom_range(0, 59));
      exp_q.push_back(pk(m_h, m_m, m_s, 0, 0, 1));
      step();
      bus.LOAD = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rnd_bad[%0d]: got %s want %s", k, fmt(obs), fmt(exp));
      end
    end
  endtask

  // Main sequence
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst         = 1'b1;
    bus.EN      = 1'b0;
    bus.LOAD    = 1'b0;
    bus.LD_HOUR = '0;
    bus.LD_MIN  = '0;
    bus.LD_SEC  = '0;
    #1;
    test_reset();
    test_carry();
    test_midnight();
    test_bad_load();
    test_freeze();
    test_collision();
    test_random_load();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
